// File: rtl/inst_prefetch_unit_if.sv
// Bundle of the cache-side request port and the dedicated memory read port of the prefetcher.
// The prefetcher uses the slave modport; the cache/memory side uses master.
interface inst_prefetch_unit_if #(
    parameter int unsigned CACHE_LINE_SIZE = 256
);
    logic                       prefetch;
    logic [31:0]                prefetch_addr;
    logic                       flush_prefetch;
    logic                       mem_busy;
    logic                       pf_mem_resp;
    logic [CACHE_LINE_SIZE-1:0] pf_mem_rdata;
    logic                       pf_mem_read;
    logic [31:0]                pf_mem_addr;
    logic                       active_prefetch;
    logic                       prefetch_rvalid;
    logic [31:0]                prefetch_raddr;
    logic [CACHE_LINE_SIZE-1:0] prefetch_rdata;

    modport master (
        output prefetch, prefetch_addr, flush_prefetch, mem_busy, pf_mem_resp, pf_mem_rdata,
        input  pf_mem_read, pf_mem_addr, active_prefetch, prefetch_rvalid, prefetch_raddr,
               prefetch_rdata
    );

    modport slave (
        input  prefetch, prefetch_addr, flush_prefetch, mem_busy, pf_mem_resp, pf_mem_rdata,
        output pf_mem_read, pf_mem_addr, active_prefetch, prefetch_rvalid, prefetch_raddr,
               prefetch_rdata
    );
endinterface

// File: rtl/inst_prefetch_unit.sv
// Next-line instruction prefetcher: fetches one requested line when memory is idle and holds it
// until the cache flushes it. Define INST_PREFETCH_FILTER_EN to drop repeats of the last line.
module inst_prefetch_unit #(
    parameter int unsigned CACHE_LINE_SIZE = 256
) (
    input logic                 clk,
    input logic                 rst,
    inst_prefetch_unit_if.slave bus
);
    localparam int unsigned Offset = $clog2(CACHE_LINE_SIZE / 8);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StValid} state_t;

    state_t                     state;
    logic [31:Offset]           line_addr;
    logic [CACHE_LINE_SIZE-1:0] line_data;
    logic                       drop;
    logic                       filter_hit;
    logic                       issue;

    logic unused_offset;
    assign unused_offset = ^bus.prefetch_addr[Offset-1:0];

`ifdef INST_PREFETCH_FILTER_EN
    logic [31:Offset] last_line;
    logic             last_valid;

    assign filter_hit = last_valid && (last_line == bus.prefetch_addr[31:Offset]);
`else
    assign filter_hit = 1'b0;
`endif

    // Cancel outranks a replacing request, which outranks the read issue.
    assign issue = (state == StReq) && !bus.flush_prefetch && !bus.prefetch && !bus.mem_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            line_addr <= '0;
            line_data <= '0;
            drop      <= 1'b0;
`ifdef INST_PREFETCH_FILTER_EN
            last_line  <= '0;
            last_valid <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.prefetch && !filter_hit) begin
                        line_addr <= bus.prefetch_addr[31:Offset];
                        drop      <= 1'b0;
                        state     <= StReq;
                    end
                end
                StReq: begin
                    if (bus.flush_prefetch) begin
                        state <= StIdle;
                    end else if (bus.prefetch) begin
                        line_addr <= bus.prefetch_addr[31:Offset];
                    end else if (!bus.mem_busy) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (bus.pf_mem_resp) begin
                        if (drop || bus.flush_prefetch) begin
                            state <= StIdle;
                        end else begin
                            line_data <= bus.pf_mem_rdata;
                            state     <= StValid;
                        end
                    end else if (bus.flush_prefetch) begin
                        // Read already in flight: remember to discard its response.
                        drop <= 1'b1;
                    end
                end
                StValid: begin
                    if (bus.flush_prefetch) begin
                        state <= StIdle;
`ifdef INST_PREFETCH_FILTER_EN
                        last_line  <= line_addr;
                        last_valid <= 1'b1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.pf_mem_read     = issue;
    assign bus.pf_mem_addr     = {line_addr, {Offset{1'b0}}};
    assign bus.active_prefetch = (state == StReq) || (state == StWait);
    assign bus.prefetch_rvalid = (state == StValid);
    assign bus.prefetch_raddr  = {line_addr, {Offset{1'b0}}};
    assign bus.prefetch_rdata  = line_data;
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Self-checking bench for inst_prefetch_unit: scoreboard of expected reads and delivered lines.
module tb_inst_prefetch_unit;
    localparam int unsigned LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_prefetch_unit_if #(.CACHE_LINE_SIZE(LW)) bus ();

    inst_prefetch_unit #(.CACHE_LINE_SIZE(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk     = 0;
    int          n_pass    = 0;
    int          read_cnt  = 0;
    logic [31:0] q_rd[$];
    logic [31:0] q_ra[$];
    logic [LW-1:0] q_rdat[$];
    logic        prev_rvalid = 1'b0;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Monitor: compare every issued read and every newly delivered line against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            chk("active_rvalid_excl", LW'(bus.active_prefetch & bus.prefetch_rvalid), '0);
            if (bus.pf_mem_read) begin
                read_cnt++;
                if (q_rd.size() == 0) chk("unexpected_read", LW'(bus.pf_mem_addr), '1);
                else chk("read_addr", LW'(bus.pf_mem_addr), LW'(q_rd.pop_front()));
            end
            if (bus.prefetch_rvalid && !prev_rvalid) begin
                if (q_ra.size() == 0) begin
                    chk("unexpected_rvalid", LW'(bus.prefetch_raddr), '1);
                end else begin
                    chk("raddr", LW'(bus.prefetch_raddr), LW'(q_ra.pop_front()));
                    chk("rdata", bus.prefetch_rdata, q_rdat.pop_front());
                end
            end
        end
        prev_rvalid = bus.prefetch_rvalid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic request(input logic [31:0] addr);
        bus.prefetch      = 1'b1;
        bus.prefetch_addr = addr;
        cyc();
        bus.prefetch = 1'b0;
    endtask

    // Returns positioned in the cycle after the read issue.
    task automatic wait_read();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (bus.pf_mem_read) begin
                ok = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        chk("read_issued", LW'(ok), LW'(1));
    endtask

    task automatic respond(input int delay, input logic [LW-1:0] data);
        repeat (delay - 1) cyc();
        bus.pf_mem_resp  = 1'b1;
        bus.pf_mem_rdata = data;
        cyc();
        bus.pf_mem_resp  = 1'b0;
        bus.pf_mem_rdata = '0;
    endtask

    task automatic do_flush();
        bus.flush_prefetch = 1'b1;
        cyc();
        bus.flush_prefetch = 1'b0;
        settle();
        chk("flush_rvalid", LW'(bus.prefetch_rvalid), '0);
        chk("flush_active", LW'(bus.active_prefetch), '0);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [LW-1:0] data, input int delay);
        q_rd.push_back(addr & 32'hFFFF_FFE0);
        q_ra.push_back(addr & 32'hFFFF_FFE0);
        q_rdat.push_back(data);
        request(addr);
        wait_read();
        respond(delay, data);
        settle();
        chk("fetch_rvalid", LW'(bus.prefetch_rvalid), LW'(1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_active"}, LW'(bus.active_prefetch), '0);
        chk({tag, "_rvalid"}, LW'(bus.prefetch_rvalid), '0);
        chk({tag, "_read"}, LW'(bus.pf_mem_read), '0);
        chk({tag, "_memaddr"}, LW'(bus.pf_mem_addr), '0);
        chk({tag, "_raddr"}, LW'(bus.prefetch_raddr), '0);
        chk({tag, "_rdata"}, bus.prefetch_rdata, '0);
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [LW-1:0] d;
        int base;

        bus.prefetch       = 1'b0;
        bus.prefetch_addr  = '0;
        bus.flush_prefetch = 1'b0;
        bus.mem_busy       = 1'b0;
        bus.pf_mem_resp    = 1'b0;
        bus.pf_mem_rdata   = '0;
        repeat (2) cyc();
        check_all_zero("reset");
        rst = 1'b0;
        cyc();

        // Basic fetch, 2-cycle memory, line held until flushed.
        d = rand_line();
        q_rd.push_back(32'h0000_1040);
        q_ra.push_back(32'h0000_1040);
        q_rdat.push_back(d);
        request(32'h0000_1040);
        settle();
        chk("req_active", LW'(bus.active_prefetch), LW'(1));
        wait_read();
        chk("wait_active", LW'(bus.active_prefetch), LW'(1));
        respond(2, d);
        settle();
        chk("basic_rvalid", LW'(bus.prefetch_rvalid), LW'(1));
        repeat (3) cyc();
        chk("hold_rvalid", LW'(bus.prefetch_rvalid), LW'(1));
        chk("hold_rdata", bus.prefetch_rdata, d);
        do_flush();

        // Busy memory with a replacing request: only the newest line is read.
        base         = read_cnt;
        bus.mem_busy = 1'b1;
        request(32'h0000_1800);
        repeat (2) cyc();
        request(32'h0000_2000);
        repeat (2) cyc();
        chk("busy_noread", LW'(read_cnt - base), '0);
        chk("busy_active", LW'(bus.active_prefetch), LW'(1));
        d = rand_line();
        q_rd.push_back(32'h0000_2000);
        q_ra.push_back(32'h0000_2000);
        q_rdat.push_back(d);
        bus.mem_busy = 1'b0;
        wait_read();
        respond(1, d);
        settle();
        chk("busy_rvalid", LW'(bus.prefetch_rvalid), LW'(1));
        chk("busy_reads", LW'(read_cnt - base), LW'(1));
        do_flush();

        // Cancel while the read is outstanding: response is discarded.
        q_rd.push_back(32'h0000_4000);
        request(32'h0000_4000);
        wait_read();
        bus.flush_prefetch = 1'b1;
        cyc();
        bus.flush_prefetch = 1'b0;
        cyc();
        respond(1, rand_line());
        settle();
        chk("cancel_rvalid", LW'(bus.prefetch_rvalid), '0);
        chk("cancel_idle", LW'(bus.active_prefetch), '0);
        fetch(32'h0000_5000, rand_line(), 1);
        do_flush();

        // Reset mid-fetch, then a stale response.
        q_rd.push_back(32'h0000_6000);
        request(32'h0000_6000);
        wait_read();
        rst = 1'b1;
        settle();
        check_all_zero("rst_wait");
        cyc();
        rst = 1'b0;
        cyc();
        respond(1, rand_line());
        settle();
        chk("stale_rvalid", LW'(bus.prefetch_rvalid), '0);
        chk("stale_active", LW'(bus.active_prefetch), '0);
        chk("stale_rdata", bus.prefetch_rdata, '0);

        // Offset bits ignored; prefetch held high in WAIT/VALID issues nothing extra.
        base = read_cnt;
        d    = rand_line();
        q_rd.push_back(32'h0);
        q_ra.push_back(32'h0);
        q_rdat.push_back(d);
        request(32'h0000_001F);
        wait_read();
        bus.prefetch      = 1'b1;
        bus.prefetch_addr = 32'h0000_001F;
        respond(1, d);
        repeat (3) cyc();
        chk("held_rvalid", LW'(bus.prefetch_rvalid), LW'(1));
        chk("held_raddr", LW'(bus.prefetch_raddr), '0);
        chk("held_reads", LW'(read_cnt - base), LW'(1));
        bus.prefetch = 1'b0;
        do_flush();
        fetch(32'hFFFF_FFFF, rand_line(), 3);
        do_flush();

        // Repeat of the last flushed line.
        fetch(32'h0000_3000, rand_line(), 1);
        do_flush();
        base = read_cnt;
`ifdef INST_PREFETCH_FILTER_EN
        request(32'h0000_3000);
        repeat (4) cyc();
        chk("filter_noread", LW'(read_cnt - base), '0);
        chk("filter_idle", LW'(bus.active_prefetch), '0);
        fetch(32'h0000_3020, rand_line(), 1);
        do_flush();
`else
        fetch(32'h0000_3000, rand_line(), 1);
        do_flush();
        chk("nofilter_reads", LW'(read_cnt - base), LW'(1));
`endif

        repeat (2) cyc();
        chk("rd_queue_empty", LW'(q_rd.size()), '0);
        chk("line_queue_empty", LW'(q_ra.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
